// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame writer: HD44780 command bytes,
// DDRAM row base addresses, the controller state encoding and small helpers.
package lcd_pkg;

  // HD44780 command bytes used by the controller
  localparam logic [7:0] FUNC_SET_4B2L = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] DISP_ON       = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CLEAR         = 8'h01;  // clear display, home cursor
  localparam logic [7:0] ENTRY_INC     = 8'h06;  // auto-increment, no shift
  localparam logic [7:0] SET_DDRAM     = 8'h80;  // OR with a DDRAM address

  localparam int INIT_LEN = 4;

  // DDRAM start address of each display row (rows 2/3 continue rows 0/1)
  localparam logic [3:0][7:0] ROW_BASE = {8'h54, 8'h14, 8'h40, 8'h00};

  // Controller states; the SEND_* states belong to the byte sender, which
  // also uses IDLE as its "nothing in flight" state
  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ROW_ADDR,
    CHAR,
    SEND_STRB,
    SEND_HOLD,
    SEND_BUSY,
    SEND_GAP
  } lcd_state_t;

  // Address width that never collapses to zero bits
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Power-up command sequence, in order
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return FUNC_SET_4B2L;
      2'd1:    return DISP_ON;
      2'd2:    return CLEAR;
      default: return ENTRY_INC;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_sender.sv
// Byte-level handshake towards LCD_write: one-cycle strobe, one cycle where
// Busy is not yet trustworthy, wait for Busy to drop, then an idle gap
// (lengthened by CLEAR_WAIT after a Clear command) before accepting more.
module lcd_byte_sender
  import lcd_pkg::*;
#(
  parameter int GAP_CYCLES = 8,
  parameter int CLEAR_WAIT = 2048
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic [7:0] start_data,
  input  logic       start_rs,
  input  logic       start_long,
  input  logic       lcd_busy,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_strb,
  output logic       ready
);

  localparam int WAIT_MAX = GAP_CYCLES + CLEAR_WAIT;
  localparam int CNT_W    = clog2_min1(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LEN  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LEN = CNT_W'(WAIT_MAX);

  lcd_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       data_reg;
  logic             rs_reg;
  logic             strb_reg;
  logic             long_reg;
  logic [CNT_W-1:0] wait_len;

  assign wait_len = long_reg ? LONG_LEN : GAP_LEN;

  // Strobe / busy-wait / gap sequencer; data and rs hold until the next strobe
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      data_reg  <= 8'h00;
      rs_reg    <= 1'b0;
      strb_reg  <= 1'b0;
      long_reg  <= 1'b0;
    end else begin
      case (state_reg)
        SEND_STRB: begin
          strb_reg  <= 1'b0;
          state_reg <= SEND_HOLD;
        end
        // LCD_write has not raised Busy yet in this cycle
        SEND_HOLD: state_reg <= SEND_BUSY;
        SEND_BUSY: begin
          if (!lcd_busy) begin
            if (wait_len == '0) begin
              state_reg <= IDLE;
            end else begin
              cnt_reg   <= wait_len;
              state_reg <= SEND_GAP;
            end
          end
        end
        SEND_GAP: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          // Idle: Busy is ignored here, only a new request matters
          if (start) begin
            data_reg  <= start_data;
            rs_reg    <= start_rs;
            long_reg  <= start_long;
            strb_reg  <= 1'b1;
            state_reg <= SEND_STRB;
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  assign lcd_data = data_reg;
  assign lcd_rs   = rs_reg;
  assign lcd_strb = strb_reg;
  assign ready    = (state_reg == IDLE);

endmodule

// File: rtl/lcd_frame_writer.sv
// ROWS x COLS character frame buffer streamed to an HD44780-style 4-bit
// writer. Runs the LCD init sequence after reset, then sends one full frame
// (row address command + COLS characters per row) per refresh request.
// Optional build macro LCD_CLEAR_EACH_FRAME_EN: prefix every frame with a
// Clear command (plus CLEAR_WAIT cycles) instead of overwriting in place.
module lcd_frame_writer
  import lcd_pkg::*;
#(
  parameter int COLS       = 16,
  parameter int ROWS       = 2,
  parameter int GAP_CYCLES = 8,
  parameter int CLEAR_WAIT = 2048,
  localparam int ROW_W     = clog2_min1(ROWS),
  localparam int COL_W     = clog2_min1(COLS)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_col,
  input  logic [7:0]       wr_char,
  input  logic             refresh,
  input  logic             lcd_busy,
  output logic [7:0]       lcd_data,
  output logic             lcd_rs,
  output logic             lcd_strb,
  output logic             ready,
  output logic             frame_done
);

  localparam int ADDR_W = ROW_W + COL_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
`ifdef LCD_CLEAR_EACH_FRAME_EN
  localparam logic CLEAR_EACH_FRAME = 1'b1;
`else
  localparam logic CLEAR_EACH_FRAME = 1'b0;
`endif

  // Frame buffer addressed as {row, col}; cells power up as spaces and are
  // deliberately not touched by reset so a reset keeps the displayed text
  logic [7:0]        frame_mem [DEPTH] = '{default: 8'h20};
  logic [7:0]        rd_data_reg;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_in_range;

  lcd_state_t       state_reg;
  lcd_state_t       ret_state_reg;
  logic [ROW_W-1:0] row_reg;
  logic [COL_W-1:0] col_reg;
  logic [1:0]       init_idx_reg;
  logic             pending_reg;
  logic             wait_reg;
  logic             last_reg;
  logic             clr_reg;
  logic             ready_reg;
  logic             frame_done_reg;

  logic       snd_ready;
  logic       snd_start;
  logic [7:0] snd_data;
  logic       snd_rs;
  logic       snd_long;

  // Set-DDRAM-address command for each physical row
  logic [7:0] row_cmd [ROWS];
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_cmd
    assign row_cmd[gi] = SET_DDRAM | ROW_BASE[gi];
  end

  assign wr_in_range = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
  assign wr_addr     = {wr_row, wr_col};
  assign rd_addr     = {row_reg, col_reg};

  // Buffer port: writes any cycle, registered read-first read of the cell
  // the sequencer is pointing at (refreshed every cycle while a byte is out)
  always_ff @(posedge CLK) begin
    if (wr_en && wr_in_range) begin
      frame_mem[wr_addr] <= wr_char;
    end
    rd_data_reg <= frame_mem[rd_addr];
  end

  // Byte to issue this cycle; only when the sender is free and not already
  // waiting on the previous byte
  always_comb begin
    snd_start = 1'b0;
    snd_data  = 8'h00;
    snd_rs    = 1'b0;
    snd_long  = 1'b0;
    if (!wait_reg && snd_ready) begin
      case (state_reg)
        INIT: begin
          snd_start = 1'b1;
          snd_data  = init_cmd(init_idx_reg);
          snd_long  = (init_cmd(init_idx_reg) == CLEAR);
        end
        ROW_ADDR: begin
          snd_start = 1'b1;
          if (clr_reg) begin
            snd_data = CLEAR;
            snd_long = 1'b1;
          end else begin
            snd_data = row_cmd[row_reg];
          end
        end
        CHAR: begin
          snd_start = 1'b1;
          snd_data  = rd_data_reg;
          snd_rs    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Frame sequencer: every issued byte advances row/col immediately and
  // records where to resume once the sender reports it is free again
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg      <= INIT;
      ret_state_reg  <= INIT;
      row_reg        <= '0;
      col_reg        <= '0;
      init_idx_reg   <= '0;
      pending_reg    <= 1'b0;
      wait_reg       <= 1'b0;
      last_reg       <= 1'b0;
      clr_reg        <= 1'b0;
      ready_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      ready_reg      <= 1'b0;
      if (refresh && state_reg != IDLE) begin
        pending_reg <= 1'b1;
      end
      if (snd_start) begin
        wait_reg <= 1'b1;
      end else if (wait_reg && snd_ready) begin
        wait_reg  <= 1'b0;
        state_reg <= ret_state_reg;
        if (last_reg) begin
          frame_done_reg <= 1'b1;
          last_reg       <= 1'b0;
        end
      end
      case (state_reg)
        INIT: begin
          if (snd_start) begin
            init_idx_reg  <= init_idx_reg + 2'd1;
            ret_state_reg <= (init_idx_reg == 2'(INIT_LEN - 1)) ? IDLE : INIT;
          end
        end
        IDLE: begin
          if (refresh || pending_reg) begin
            pending_reg <= 1'b0;
            row_reg     <= '0;
            col_reg     <= '0;
            clr_reg     <= CLEAR_EACH_FRAME;
            state_reg   <= ROW_ADDR;
          end else begin
            ready_reg <= 1'b1;
          end
        end
        ROW_ADDR: begin
          if (snd_start) begin
            if (clr_reg) begin
              clr_reg       <= 1'b0;
              ret_state_reg <= ROW_ADDR;
            end else begin
              col_reg       <= '0;
              ret_state_reg <= CHAR;
            end
          end
        end
        CHAR: begin
          if (snd_start) begin
            if (col_reg == LAST_COL) begin
              if (row_reg == LAST_ROW) begin
                last_reg      <= 1'b1;
                ret_state_reg <= IDLE;
              end else begin
                row_reg       <= row_reg + ROW_W'(1);
                ret_state_reg <= ROW_ADDR;
              end
            end else begin
              col_reg       <= col_reg + COL_W'(1);
              ret_state_reg <= CHAR;
            end
          end
        end
        default: state_reg <= INIT;
      endcase
    end
  end

  lcd_byte_sender #(
    .GAP_CYCLES(GAP_CYCLES),
    .CLEAR_WAIT(CLEAR_WAIT)
  ) u_sender (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (snd_start),
    .start_data(snd_data),
    .start_rs  (snd_rs),
    .start_long(snd_long),
    .lcd_busy  (lcd_busy),
    .lcd_data  (lcd_data),
    .lcd_rs    (lcd_rs),
    .lcd_strb  (lcd_strb),
    .ready     (snd_ready)
  );

  assign ready      = ready_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Self-checking bench for lcd_frame_writer (COLS=4, ROWS=2, GAP=3, CLEAR_WAIT=10)
// with a Busy model that rises 1 cycle after each strobe for 5 cycles.
module tb_lcd_frame_writer;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int GAP  = 3;
  localparam int CW   = 10;
  localparam int BUSY_LEN = 5;
`ifdef LCD_CLEAR_EACH_FRAME_EN
  localparam int CLR_EXTRA = 1;
`else
  localparam int CLR_EXTRA = 0;
`endif
  localparam int FRAME_LEN = ROWS * (1 + COLS) + CLR_EXTRA;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       wr_en = 1'b0;
  logic [0:0] wr_row = '0;
  logic [1:0] wr_col = '0;
  logic [7:0] wr_char = 8'h00;
  logic       refresh = 1'b0;
  logic       lcd_busy = 1'b0;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_strb;
  logic       ready;
  logic       frame_done;

  lcd_frame_writer #(
    .COLS(COLS), .ROWS(ROWS), .GAP_CYCLES(GAP), .CLEAR_WAIT(CW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_char(wr_char), .refresh(refresh), .lcd_busy(lcd_busy),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_strb(lcd_strb),
    .ready(ready), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Observation state
  int         cyc = 0;
  logic       rst_applied = 1'b0;
  logic [8:0] strobes[$];
  int         strobe_cyc[$];
  int         fd_cyc[$];
  int         fd_count = 0;
  int         hold_viol = 0;
  int         rst_viol = 0;
  logic [8:0] last_byte = 9'h000;
  int         bcnt = 0;

  // Reference model: what the game logic has written, and the expected frame
  logic [7:0] model_buf [ROWS][COLS];
  logic [8:0] exp_q[$];

  always @(posedge CLK) begin
    cyc         <= cyc + 1;
    rst_applied <= !RESET;
  end

  // Busy model of LCD_write
  always @(negedge CLK) begin
    if (!RESET) begin
      lcd_busy = 1'b0;
      bcnt = 0;
    end else if (lcd_strb) begin
      lcd_busy = 1'b0;
      bcnt = BUSY_LEN;
    end else if (bcnt > 0) begin
      lcd_busy = 1'b1;
      bcnt--;
    end else begin
      lcd_busy = 1'b0;
    end
  end

  // Output monitor
  always @(negedge CLK) begin
    if (rst_applied) begin
      if (lcd_strb !== 1'b0 || lcd_data !== 8'h00 || lcd_rs !== 1'b0 ||
          ready !== 1'b0 || frame_done !== 1'b0) rst_viol++;
      last_byte = 9'h000;
    end else begin
      if (lcd_strb === 1'b1) begin
        strobes.push_back({lcd_rs, lcd_data});
        strobe_cyc.push_back(cyc);
        last_byte = {lcd_rs, lcd_data};
      end else if ({lcd_rs, lcd_data} !== last_byte) begin
        hold_viol++;
      end
      if (frame_done === 1'b1) begin
        fd_count++;
        fd_cyc.push_back(cyc);
      end
    end
  end

  // DDRAM layout: rows 0/1 at 0x00/0x40, rows 2/3 continue 20 cells later
  function automatic logic [7:0] ddram_base(input int r);
    return 8'((r % 2) * 64 + (r / 2) * 20);
  endfunction

  function automatic void build_frame();
    exp_q.delete();
    if (CLR_EXTRA != 0) exp_q.push_back({1'b0, 8'h01});
    for (int r = 0; r < ROWS; r++) begin
      exp_q.push_back({1'b0, 8'h80 | ddram_base(r)});
      for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, model_buf[r][c]});
    end
  endfunction

  function automatic void clear_log();
    strobes.delete();
    strobe_cyc.delete();
    fd_cyc.delete();
  endfunction

  task automatic write_cell(input int r, input int c, input logic [7:0] ch);
    @(negedge CLK);
    wr_en = 1'b1; wr_row = 1'(r); wr_col = 2'(c); wr_char = ch;
    @(negedge CLK);
    wr_en = 1'b0;
    model_buf[r][c] = ch;
  endtask

  task automatic pulse_refresh();
    @(negedge CLK); refresh = 1'b1;
    @(negedge CLK); refresh = 1'b0;
  endtask

  task automatic wait_ready(input int budget, input string name);
    int n = 0;
    while (ready !== 1'b1 && n < budget) begin @(negedge CLK); n++; end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s: ready=%b after %0d cycles, required 1", name, ready, budget);
    end
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n = 0;
    while (fd_count < target && n < budget) begin @(negedge CLK); n++; end
    n_cmp++;
    if (fd_count < target) begin
      n_err++;
      $display("FAIL %s: frame_done count %0d, required %0d", name, fd_count, target);
    end
  endtask

  task automatic wait_strobes(input int target, input int budget, input string name);
    int n = 0;
    while (strobes.size() < target && n < budget) begin @(negedge CLK); n++; end
    n_cmp++;
    if (strobes.size() < target) begin
      n_err++;
      $display("FAIL %s: strobes seen %0d, required %0d", name, strobes.size(), target);
    end
  endtask

  task automatic check_frame(input string name, input int offset);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (offset + i >= strobes.size()) begin
        n_err++;
        $display("FAIL %s[%0d]: no strobe, required %03h", name, i, exp_q[i]);
      end else if (strobes[offset + i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s[%0d]: got rs/data %03h, required %03h", name, i,
                 strobes[offset + i], exp_q[i]);
      end else begin
        $display("  %s[%0d] rs=%0d data=%02h", name, i, strobes[offset + i][8],
                 strobes[offset + i][7:0]);
      end
    end
  endtask

  // Every strobe must leave the Busy window plus the gap (and clear wait)
  task automatic check_gaps(input string name);
    int bad = 0;
    for (int i = 1; i < strobes.size(); i++) begin
      int need = 1 + BUSY_LEN + GAP;
      if (strobes[i-1] == {1'b0, 8'h01}) need += CW;
      if (strobe_cyc[i] - strobe_cyc[i-1] < need) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s: %0d strobes too early, required 0", name, bad);
    end
  endtask

  task automatic check_init(input string name);
    logic [8:0] seq [4];
    seq[0] = {1'b0, 8'h28}; seq[1] = {1'b0, 8'h0C};
    seq[2] = {1'b0, 8'h01}; seq[3] = {1'b0, 8'h06};
    n_cmp++;
    if (strobes.size() != 4) begin
      n_err++;
      $display("FAIL %s_count: got %0d strobes, required 4", name, strobes.size());
    end
    for (int i = 0; i < 4 && i < strobes.size(); i++) begin
      n_cmp++;
      if (strobes[i] !== seq[i]) begin
        n_err++;
        $display("FAIL %s[%0d]: got %03h, required %03h", name, i, strobes[i], seq[i]);
      end else begin
        $display("  %s[%0d] cmd=%02h", name, i, strobes[i][7:0]);
      end
    end
    check_gaps({name, "_gaps"});
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (6) @(negedge CLK);
    n_cmp++;
    if (rst_viol != 0) begin
      n_err++;
      $display("FAIL reset_outputs: %0d non-zero output samples, required 0", rst_viol);
    end
    n_cmp++;
    if (strobes.size() != 0) begin
      n_err++;
      $display("FAIL reset_strobe: %0d strobes in reset, required 0", strobes.size());
    end
    clear_log();
    RESET = 1'b1;
    wait_ready(2000, "init_ready");
    check_init("init");
    n_cmp++;
    if (fd_count != 0) begin
      n_err++;
      $display("FAIL init_frame_done: %0d pulses, required 0", fd_count);
    end
  endtask

  task automatic test_frame();
    string s0 = "ABCD";
    string s1 = "WXYZ";
    int base = fd_count;
    for (int c = 0; c < COLS; c++) write_cell(0, c, s0[c]);
    for (int c = 0; c < COLS; c++) write_cell(1, c, s1[c]);
    clear_log();
    build_frame();
    pulse_refresh();
    wait_frames(base + 1, 2000, "frame_wait");
    repeat (40) @(negedge CLK);
    check_frame("frame", 0);
    check_gaps("frame_gaps");
    n_cmp++;
    if (strobes.size() != FRAME_LEN) begin
      n_err++;
      $display("FAIL frame_len: got %0d strobes, required %0d", strobes.size(), FRAME_LEN);
    end
    n_cmp++;
    if (fd_count != base + 1 || fd_cyc.size() != 1 || strobe_cyc.size() == 0 ||
        fd_cyc[0] <= strobe_cyc[strobe_cyc.size()-1]) begin
      n_err++;
      $display("FAIL frame_done_once: got %0d pulses, required 1 after last strobe",
               fd_count - base);
    end
    wait_ready(100, "frame_ready");
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 3; k++) begin
      int base = fd_count;
      int nw = $urandom_range(8, 3);
      for (int w = 0; w < nw; w++)
        write_cell($urandom_range(ROWS-1), $urandom_range(COLS-1), 8'($urandom_range(126, 33)));
      clear_log();
      build_frame();
      pulse_refresh();
      wait_frames(base + 1, 2000, "rand_wait");
      check_frame($sformatf("rand%0d", k), 0);
      wait_ready(100, "rand_ready");
    end
  endtask

  task automatic test_coalesce();
    int base = fd_count;
    clear_log();
    build_frame();
    pulse_refresh();
    wait_strobes(3, 500, "coal_start");
    repeat (3) begin
      pulse_refresh();
      repeat (4) @(negedge CLK);
    end
    wait_frames(base + 2, 3000, "coal_wait");
    repeat (200) @(negedge CLK);
    n_cmp++;
    if (fd_count != base + 2) begin
      n_err++;
      $display("FAIL coal_frames: got %0d frames, required 2", fd_count - base);
    end
    n_cmp++;
    if (strobes.size() != 2 * FRAME_LEN) begin
      n_err++;
      $display("FAIL coal_len: got %0d strobes, required %0d", strobes.size(), 2 * FRAME_LEN);
    end
    check_frame("coal_f1", 0);
    check_frame("coal_f2", FRAME_LEN);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL coal_idle: ready=%b, required 1", ready);
    end
  endtask

  task automatic test_midframe_write();
    int base = fd_count;
    logic [7:0] old00 = model_buf[0][0];
    clear_log();
    pulse_refresh();
    wait_strobes(CLR_EXTRA + 2, 500, "mid_start");
    write_cell(1, 3, 8'h21);
    write_cell(0, 0, 8'h51);
    build_frame();
    exp_q[CLR_EXTRA + 1] = {1'b1, old00};
    wait_frames(base + 1, 2000, "mid_wait");
    check_frame("mid_f1", 0);
    wait_ready(100, "mid_ready");
    build_frame();
    pulse_refresh();
    wait_frames(base + 2, 2000, "mid_wait2");
    check_frame("mid_f2", FRAME_LEN);
    wait_ready(100, "mid_ready2");
  endtask

  task automatic test_reset_midframe();
    int base = fd_count;
    clear_log();
    pulse_refresh();
    wait_strobes(CLR_EXTRA + 3, 500, "rstmid_start");
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (lcd_strb !== 1'b0 || lcd_data !== 8'h00 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_abort: strb=%b data=%02h ready=%b, required 0/00/0",
               lcd_strb, lcd_data, ready);
    end
    repeat (3) @(negedge CLK);
    clear_log();
    RESET = 1'b1;
    wait_ready(2000, "rstmid_ready");
    check_init("rstmid_init");
    n_cmp++;
    if (fd_count != base) begin
      n_err++;
      $display("FAIL rstmid_abort_fd: %0d pulses, required 0", fd_count - base);
    end
    clear_log();
    build_frame();
    pulse_refresh();
    wait_frames(base + 1, 2000, "rstmid_wait");
    check_frame("rstmid_frame", 0);
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model_buf[r][c] = 8'h20;
    test_reset();
    test_frame();
    test_random_frames();
    test_coalesce();
    test_midframe_write();
    test_reset_midframe();
    n_cmp++;
    if (hold_viol != 0) begin
      n_err++;
      $display("FAIL data_hold: %0d changes between strobes, required 0", hold_viol);
    end
    n_cmp++;
    if (rst_viol != 0) begin
      n_err++;
      $display("FAIL reset_outputs_all: %0d non-zero samples, required 0", rst_viol);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_frame_writer.md
Name: lcd_frame_writer

Overview:
- Parametrised successor to the hard-coded LCD text sequencer.
- Holds a ROWS x COLS character frame buffer that the game logic fills by address.
- On each refresh request, streams the whole frame to the HD44780-style 4-bit writer (`LCD_write`) through its Strb/Busy handshake.
- Runs the LCD init sequence once after reset; sits between game/score logic and `LCD_write`.

Parameters:
- COLS, 16, characters per row (1..40)
- ROWS, 2, display rows (1, 2 or 4)
- GAP_CYCLES, 8, idle cycles after each Busy deassertion before the next strobe (0 = none)
- CLEAR_WAIT, 2048, extra idle cycles after a Clear command

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-low reset
- wr_en  in  1  frame-buffer write strobe
- wr_row  in  $clog2(ROWS) (min 1)  row address
- wr_col  in  $clog2(COLS)  column address
- wr_char  in  8  ASCII code
- refresh  in  1  request a full-frame transfer (level or pulse)
- lcd_busy  in  1  Busy from `LCD_write`
- lcd_data  out  8  byte to `LCD_write` D_in
- lcd_rs  out  1  0 = command, 1 = data
- lcd_strb  out  1  one-cycle write strobe
- ready  out  1  idle, init complete, no pending refresh
- frame_done  out  1  one-cycle pulse after the last character of a frame

Behaviour:
- Reset (RESET==0 at a CLK edge):
  - FSM to INIT; lcd_strb=0, lcd_data=0, lcd_rs=0, ready=0, frame_done=0; pending flag and counters cleared.
  - Buffer contents are not cleared. Buffer entries power up as 8'h20 (space) via initial value.
  - Reset mid-transfer aborts immediately; init reruns.
- Byte send sub-sequence (SEND):
  - Cycle 0: lcd_strb=1 with lcd_data/lcd_rs valid.
  - Cycle 1: ignore lcd_busy.
  - Then wait while lcd_busy==1.
  - Then count GAP_CYCLES idle cycles.
  - Then continue. lcd_data/lcd_rs hold their value from strobe until the next strobe.
- INIT: sends commands 8'h28, 8'h0C, 8'h01 (followed by CLEAR_WAIT extra cycles), 8'h06, all with rs=0. Then goes to IDLE.
- IDLE: ready=1 unless pending. If refresh==1 or pending==1: clear pending, go to ROW_ADDR with row=0.
- ROW_ADDR: sends command (rs=0) 8'h80 | base[row], where base = 00, 40, 14, 54 (hex) for rows 0..3. Then col=0, go to CHAR.
- CHAR:
  - Reads buf[row][col] and sends it with rs=1.
  - If col==COLS-1: if row==ROWS-1, pulse frame_done and go to IDLE; else row+1 and go to ROW_ADDR. Otherwise col+1.
- Frame length: exactly ROWS*(1+COLS) strobes.
- Refresh asserted while not in IDLE (including during INIT): sets pending. Exactly one extra frame follows; multiple requests coalesce.
- Buffer writes:
  - Accepted every cycle regardless of FSM state.
  - Out-of-range row/col writes are ignored.
  - Same-cycle write and read of the same cell returns the old value (read-first). The new value appears in the next frame.
- lcd_busy is never asserted in IDLE in normal operation. If it is, it is ignored until the next SEND.

Optional Feature:
- LCD_CLEAR_EACH_FRAME_EN:
  - Defined: every frame starts with command 8'h01 plus CLEAR_WAIT cycles before the first ROW_ADDR. Strobes per frame become ROWS*(1+COLS)+1.
  - Undefined: no clear; cells are overwritten in place.

Decomposition:
- Shared package `lcd_pkg`: command constants (FUNC_SET_4B2L = 8'h28, DISP_ON = 8'h0C, CLEAR = 8'h01, ENTRY_INC = 8'h06, SET_DDRAM = 8'h80), row-base table, FSM state enum (INIT, IDLE, ROW_ADDR, CHAR, SEND_STRB, SEND_HOLD, SEND_BUSY, SEND_GAP).
- One natural sub-module: `lcd_byte_sender`, which owns the SEND strobe/busy/gap handshake and the gap/clear-wait counter.
- `LCD_write` stays outside; the top level wires the two together.

Test Plan:
- Use COLS=4, ROWS=2, GAP_CYCLES=3, CLEAR_WAIT=10, with a bench Busy model that goes high for 5 cycles, starting 1 cycle after each strobe.
- Reset release -> strobes 28, 0C, 01, 06 (rs=0); ≥10 extra idle cycles after 01; then ready=1; lcd_data=00, lcd_strb=0 throughout reset.
- Write "ABCD" / "WXYZ", pulse refresh -> strobe sequence 80, 41, 42, 43, 44, C0, 57, 58, 59, 5A with correct rs; frame_done pulses once after 5A; exactly 10 strobes.
- Three refresh pulses during a frame -> exactly one additional frame, then IDLE.
- Write cell (1,3)='!' during the row-0 transfer -> the same frame ends with 21. Write (0,0)='Q' after 80 is sent -> the current frame still sends 41 and the next frame sends 51.
- Assert RESET=0 in the middle of the CHAR state -> lcd_strb=0 next cycle, init sequence restarts, buffer contents are retained on the next frame.
- With LCD_CLEAR_EACH_FRAME_EN -> each frame begins with 01 plus ≥10 idle cycles, 11 strobes per frame.
